// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// wait-counter width and the address legality check.
package dmem_pkg;

  // Width of the WAIT_CYCLES down-counter (covers 0..15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // A request is rejected when it is not word aligned or when any byte
  // address bit above the stored word range is set.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for data_memory_resp: synchronous write with per-byte
// enables, combinational read. Contents are not reset.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);

  logic [31:0] mem [(1 << ADDR_W)];

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wd[8*b +: 8];
        end
      end
    end
  end

  assign rd = mem[addr];

endmodule

// File: rtl/data_memory_resp.sv
// data_memory_resp: single-outstanding data memory with a fixed response
// latency of WAIT_CYCLES+1 cycles after the accepting edge.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while idle. The response
// is a one-cycle resp_valid pulse with no back-pressure; resp_rd/resp_err
// are zero whenever resp_valid is low.
//
// Optional feature macro: DMEM_BYTE_STROBE_EN adds req_be[3:0] byte strobes
// for writes. Without it, writes always update the full word.
module data_memory_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  output logic [31:0] resp_rd,
  output logic        resp_err,
  output dmem_state_e dbg_state
);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_en_q;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wd_q;
  logic [3:0]        be_q;
  logic              accept;
  logic              mem_we;
  logic [31:0]       mem_rd;

  // req_ready stays low during reset and rises on the first edge after it.
  assign req_ready = (state_q == IDLE) && ready_en_q;
  assign accept    = req_valid && req_ready;

  // State, counter and request capture; capture only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wd_q       <= '0;
`ifdef DMEM_BYTE_STROBE_EN
      be_q       <= 4'h0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        we_q  <= req_we;
        err_q <= addr_err(req_addr, ADDR_W);
        idx_q <= req_addr[ADDR_W+1:2];
        wd_q  <= req_wd;
`ifdef DMEM_BYTE_STROBE_EN
        be_q  <= req_be;
`endif
      end
    end
  end

`ifndef DMEM_BYTE_STROBE_EN
  assign be_q = 4'hF;
`endif

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The write lands on the edge that ends the RESP cycle; rejected requests never write.
  assign mem_we = (state_q == RESP) && we_q && !err_q;

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (be_q),
    .addr (idx_q),
    .wd   (wd_q),
    .rd   (mem_rd)
  );

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rd    = (resp_valid && !we_q && !err_q) ? mem_rd : 32'd0;
  assign dbg_state  = state_q;

endmodule

// File: doc/data_memory_resp.md
DATA_MEMORY_RESP -- requirements
Module: data_memory_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of the number of 32-bit words stored (1024 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning cycles between request acceptance and response (legal range 0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning the CPU presents a request.
REQ-006 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1, meaning write (1) or read (0).
REQ-008 SHALL have port req_addr, input, 32, meaning the byte address.
REQ-009 SHALL have port req_wd, input, 32, meaning the write data.
REQ-010 SHALL have port resp_valid, output, 1, meaning a one-cycle response pulse.
REQ-011 SHALL have port resp_rd, output, 32, meaning read data, valid only with resp_valid.
REQ-012 SHALL have port resp_err, output, 1, meaning the request was rejected, valid only with resp_valid.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted when req_valid & req_ready at a rising edge.
REQ-015 SHALL latch we, addr and wd on acceptance; later input changes have no effect until resp_valid.
REQ-016 SHALL go IDLE->WAIT on acceptance when WAIT_CYCLES>0, with the wait counter loaded to WAIT_CYCLES-1; otherwise IDLE->RESP.
REQ-017 SHALL decrement the counter each WAIT cycle and move WAIT->RESP when it is 0.
REQ-018 SHALL assert resp_valid for exactly the one RESP cycle, then return to IDLE; the total latency from accept edge to resp_valid is WAIT_CYCLES+1 cycles.
REQ-019 SHALL set resp_err=1 when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0; an erroring request does not modify storage and returns resp_rd=0.
REQ-020 SHALL perform the write at the RESP edge at word index addr[ADDR_W+1:2]; resp_rd for a write is 0.
REQ-021 SHALL return for a read the stored word at index addr[ADDR_W+1:2] as sampled in RESP, which includes any write completed earlier.
REQ-022 SHALL drive resp_rd=0 and resp_err=0 whenever resp_valid=0.
REQ-023 SHALL have no back-pressure on the response: the requester must accept the resp_valid pulse.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_err=0 and resp_rd=0, taking effect immediately without a clock edge.
REQ-025 SHALL drop an in-flight request on reset mid-operation (no write occurs, no response) and raise req_ready on the first edge after rst_n rises.
REQ-026 SHALL NOT reset storage contents.

Configuration
REQ-027 SHALL, with DMEM_BYTE_STROBE_EN defined, add input req_be[3:0]; a write updates only the bytes whose strobe bit is set, and req_be is latched with the request.
REQ-028 SHALL, without DMEM_BYTE_STROBE_EN, omit req_be and write full words only.

Structure
REQ-029 SHALL place the FSM state enum and the WAIT_CYCLES counter width (4) in shared package dmem_pkg.
REQ-030 SHALL use one sub-module, dmem_array: synchronous write with optional byte enables and combinational read.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to 0x10, then read 0x10 -> resp_rd=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after each accept (WAIT_CYCLES=2).
REQ-032 SHALL cover: read 0x13 (misaligned) -> resp_err=1, resp_rd=0; a later read of 0x10 still returns the prior value.
REQ-033 SHALL cover: write to 0x1000 with ADDR_W=10 -> resp_err=1; word 0 is unchanged.
REQ-034 SHALL cover: req_valid held high across back-to-back requests -> req_ready=0 in WAIT/RESP, and the second request is accepted the cycle after resp_valid.
REQ-035 SHALL cover: rst_n pulsed low during WAIT of a write of 0x12345678 to 0x20 -> no resp_valid, and a later read of 0x20 returns the old value.
REQ-036 SHALL cover, with DMEM_BYTE_STROBE_EN: write 0xAABBCCDD with be=4'b0101 over 0x11223344 -> read returns 0x11BB33DD.
